// File: rtl/barcode_pkg.sv
// Shared types and the default product table for the barcode entry matcher.
package barcode_pkg;

  localparam int DIGIT_W          = 4;
  localparam int DEF_NUM_PRODUCTS = 12;
  localparam int DEF_NUM_DIGITS   = 4;

  // Product 0 occupies the least significant 16 bits; each code is MSD first.
  localparam logic [DEF_NUM_PRODUCTS*DEF_NUM_DIGITS*DIGIT_W-1:0] DEFAULT_PRODUCT_TABLE = {
    16'h1213, 16'h1342, 16'h4321, 16'h3112, 16'h2144, 16'h2134,
    16'h3214, 16'h3133, 16'h3121, 16'h4133, 16'h4132, 16'h3124
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

endpackage

// File: rtl/barcode_prefix_match.sv
// Combinational prefix matcher: bit i is set when the top len digits of
// product i equal the top len digits of prefix.
module barcode_prefix_match
  import barcode_pkg::*;
#(
  parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DW           = DIGIT_W,
  parameter logic [NUM_PRODUCTS*NUM_DIGITS*DW-1:0] PRODUCT_TABLE = DEFAULT_PRODUCT_TABLE
) (
  input  logic [NUM_DIGITS*DW-1:0]          prefix,
  input  logic [$clog2(NUM_DIGITS+1)-1:0]   len,
  output logic [NUM_PRODUCTS-1:0]           match
);

  localparam int CODE_W = NUM_DIGITS * DW;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      match[i] = 1'b1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        // Digit d counts from the most significant end of the code.
        if ((d < int'(len)) &&
            (PRODUCT_TABLE[i*CODE_W + (NUM_DIGITS-1-d)*DW +: DW] != prefix[(NUM_DIGITS-1-d)*DW +: DW])) begin
          match[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/barcode_entry_matcher.sv
// Barcode entry buffer with live prefix highlighting and product selection.
// Optional inactivity timeout is built only when BARCODE_TIMEOUT_EN is defined.
module barcode_entry_matcher
  import barcode_pkg::*;
#(
  parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DIGIT_W      = barcode_pkg::DIGIT_W,
  parameter logic [NUM_PRODUCTS*NUM_DIGITS*DIGIT_W-1:0] PRODUCT_TABLE = DEFAULT_PRODUCT_TABLE,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                digit_valid,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                backspace,
  input  logic                                clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0]       barcode_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digits_entered,
  output logic [NUM_PRODUCTS-1:0]             highlight_mask,
  output logic [$clog2(NUM_PRODUCTS+1)-1:0]   match_count,
  output logic                                reject,
  output logic                                select_valid,
  output logic [$clog2(NUM_PRODUCTS)-1:0]     select_index,
  output logic                                timeout,
  output state_t                              state_dbg
);

  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS+1);
  localparam int MC_W  = $clog2(NUM_PRODUCTS+1);
  localparam int IDX_W = $clog2(NUM_PRODUCTS);

  // Handshake: digit_valid/backspace/clear are single-cycle strobes, always
  // consumed on the clock edge where they are high (no ready back-pressure);
  // reject and select_valid answer them one cycle later as one-cycle pulses.

  state_t                   state_q, state_d;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_PRODUCTS-1:0]  mask_q, mask_d;
  logic [MC_W-1:0]          mcount_q, mcount_d;
  logic                     reject_q, reject_d;
  logic                     sel_v_q, sel_v_d;
  logic [IDX_W-1:0]         sel_i_q, sel_i_d;
  logic                     activity;

  logic [BUF_W-1:0]         cand_buf;
  logic [CNT_W-1:0]         cand_len;
  logic [NUM_PRODUCTS-1:0]  cand_match;
  logic [NUM_PRODUCTS-1:0]  buf_match;

  barcode_prefix_match #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .NUM_DIGITS   (NUM_DIGITS),
    .DW           (DIGIT_W),
    .PRODUCT_TABLE(PRODUCT_TABLE)
  ) u_cand_match (
    .prefix(cand_buf),
    .len   (cand_len),
    .match (cand_match)
  );

  barcode_prefix_match #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .NUM_DIGITS   (NUM_DIGITS),
    .DW           (DIGIT_W),
    .PRODUCT_TABLE(PRODUCT_TABLE)
  ) u_buf_match (
    .prefix(buf_d),
    .len   (cnt_d),
    .match (buf_match)
  );

`ifdef BARCODE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    cand_buf = buf_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (d == int'(cnt_q)) cand_buf[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W] = digit_in;
    end
    cand_len = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    sel_v_d  = 1'b0;
    sel_i_d  = '0;
    activity = 1'b0;

    if (state_q == ST_COMPLETE) begin
      state_d = ST_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
    end else if (clear) begin
      activity = 1'b1;
      state_d  = ST_IDLE;
      buf_d    = '0;
      cnt_d    = '0;
    end else if (backspace) begin
      activity = 1'b1;
      if (cnt_q != '0) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (d == int'(cnt_q) - 1) buf_d[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W] = '0;
        end
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? ST_IDLE : ST_ENTRY;
      end
    end else if (digit_valid) begin
      if (|cand_match) begin
        activity = 1'b1;
        buf_d    = cand_buf;
        cnt_d    = cand_len;
        if (cand_len == CNT_W'(NUM_DIGITS)) begin
          state_d = ST_COMPLETE;
          sel_v_d = 1'b1;
          // Scan downward so the lowest matching index wins on duplicates.
          for (int i = NUM_PRODUCTS-1; i >= 0; i--) begin
            if (cand_match[i]) sel_i_d = IDX_W'(i);
          end
        end else begin
          state_d = ST_ENTRY;
        end
      end else begin
        reject_d = 1'b1;
      end
    end

`ifdef BARCODE_TIMEOUT_EN
    tmo_d     = '0;
    timeout_d = 1'b0;
    if (state_q == ST_ENTRY && !activity) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        buf_d     = '0;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    mask_d   = (cnt_d == '0) ? '0 : buf_match;
    mcount_d = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      mcount_d = mcount_d + MC_W'(mask_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      mcount_q <= '0;
      reject_q <= 1'b0;
      sel_v_q  <= 1'b0;
      sel_i_q  <= '0;
`ifdef BARCODE_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      mcount_q <= mcount_d;
      reject_q <= reject_d;
      sel_v_q  <= sel_v_d;
      sel_i_q  <= sel_i_d;
`ifdef BARCODE_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign barcode_out    = buf_q;
  assign digits_entered = cnt_q;
  assign highlight_mask = mask_q;
  assign match_count    = mcount_q;
  assign reject         = reject_q;
  assign select_valid   = sel_v_q;
  assign select_index   = sel_i_q;
  assign state_dbg      = state_q;
`ifdef BARCODE_TIMEOUT_EN
  assign timeout        = timeout_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

// File: doc/barcode_entry_matcher.md
# barcode_entry_matcher

Sequential, parametrised barcode entry and product-matching engine for the sale terminal.
- Accepts barcode digits one at a time from the keypad decoder and holds the partial barcode.
- Keeps a registered prefix-match mask over a configurable product table, used for display highlighting.
- Rejects digits that would leave no candidate product.
- Emits a one-cycle selection pulse with the product index once a full barcode is entered.

## Interface
Parameters:
- NUM_PRODUCTS, 12: number of entries in the product table.
- NUM_DIGITS, 4: digits per barcode.
- DIGIT_W, 4: bits per digit.
- PRODUCT_TABLE, default table from barcode_pkg: NUM_PRODUCTS*NUM_DIGITS*DIGIT_W bits. Entry i sits at bits [i*NUM_DIGITS*DIGIT_W +: NUM_DIGITS*DIGIT_W]. Most significant digit comes first.
- TIMEOUT_CYCLES, 50_000_000: inactivity limit. Used only with BARCODE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- digit_valid  in  1  digit_in is presented this cycle.
- digit_in  in  DIGIT_W  entered digit value.
- backspace  in  1  remove the last entered digit.
- clear  in  1  discard the whole entry.
- barcode_out  out  NUM_DIGITS*DIGIT_W  entered digits, left-justified, unentered digits zero.
- digits_entered  out  $clog2(NUM_DIGITS+1)  count of accepted digits.
- highlight_mask  out  NUM_PRODUCTS  bit i set means product i matches the entered prefix.
- match_count  out  $clog2(NUM_PRODUCTS+1)  popcount of highlight_mask.
- reject  out  1  pulse: digit refused.
- select_valid  out  1  pulse: full barcode matched.
- select_index  out  $clog2(NUM_PRODUCTS)  matched product index, valid while select_valid is high.
- timeout  out  1  pulse: entry cleared by inactivity.

## Operation
- States:
  - IDLE: digits_entered = 0.
  - ENTRY: 0 < digits_entered < NUM_DIGITS.
  - COMPLETE: one cycle only.
- Input priority in a single cycle: clear > backspace > digit_valid. Lower-priority inputs in that cycle are ignored.
- clear: buffer zeroed, state goes to IDLE.
- backspace:
  - In ENTRY, digits_entered decrements and that digit is zeroed; reaching 0 returns to IDLE.
  - In IDLE it is a no-op.
- Digit acceptance (IDLE or ENTRY):
  - The candidate prefix is barcode_out with digit_in placed at position digits_entered.
  - If at least one product matches the candidate prefix, the digit is stored and digits_entered increments.
  - Otherwise reject pulses and the buffer is unchanged.
- Prefix match rule: product i matches when its top k digits equal the top k entered digits, where k = digits_entered.
- highlight_mask:
  - All zero when k = 0 (no highlighting in IDLE).
  - Otherwise the match vector for the current buffer.
- Completion:
  - Accepting the NUM_DIGITS-th digit moves the FSM to COMPLETE.
  - In COMPLETE, select_valid = 1 and select_index = lowest set bit of highlight_mask.
  - Next cycle the buffer clears and the FSM returns to IDLE.
  - All inputs are ignored in COMPLETE except reset.
- Duplicate table entries: the lowest index wins.

## Timing
- Reset values: barcode_out 0, digits_entered 0, highlight_mask 0, match_count 0, reject 0, select_valid 0, select_index 0, timeout 0, state IDLE.
- All outputs are registered.
- Latency: one cycle from an input edge to the buffer, mask, count and reject update.
- select_valid is asserted the cycle after the final digit is accepted, for exactly one cycle. The outputs return to IDLE values the cycle after that.
- Reset takes effect mid-entry and in COMPLETE; a pending select is discarded.
- Back-to-back digit_valid on consecutive cycles is supported at full rate.

## Configuration
- BARCODE_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter reloads to 0 on any accepted digit, backspace, clear or reset.
  - It increments only in ENTRY.
  - When it reaches TIMEOUT_CYCLES-1, the buffer clears, the FSM goes to IDLE and timeout pulses for one cycle.
- BARCODE_TIMEOUT_EN not defined: no counter is built and timeout is tied to 0.

## Structure
- barcode_pkg holds:
  - DIGIT_W;
  - the default PRODUCT_TABLE, i.e. the twelve codes 3124, 4132, 4133, 3121, 3133, 3214, 2134, 2144, 3112, 4321, 1342, 1213 for products 0–11;
  - the state enum typedef.
- Sub-module barcode_prefix_match: combinational; takes a prefix and a length and returns the NUM_PRODUCTS match vector.
  - Instance 1 evaluates the candidate prefix for acceptance.
  - Instance 2 evaluates the current buffer for highlight_mask.

## Test plan
All cases use default parameters.
- Digit 3 from IDLE -> digits_entered 1, highlight_mask 0x139, match_count 5, barcode_out 0x3000.
- Digits 3, 1 -> highlight_mask 0x119, match_count 4; then backspace -> highlight_mask 0x139, digits_entered 1.
- Digits 4, 1, 3 -> highlight_mask 0x006; then digit 3 -> select_valid one cycle later with select_index 2; the next cycle is IDLE with highlight_mask 0.
- Digits 1, 2 then digit 5 -> reject pulse; barcode_out stays 0x1200 and highlight_mask stays 0x800.
- clear, backspace and digit_valid asserted in the same cycle during entry -> buffer cleared, no reject; reset during COMPLETE -> no select_valid.
- With BARCODE_TIMEOUT_EN and TIMEOUT_CYCLES = 8: digit 2, then idle -> timeout pulses, digits_entered 0.
